// File: rtl/mem_access_sequencer.sv
// Memory-stage access sequencer: drives the 16-bit data memory and owns the stack pointer.
// Optional stack bound checking is compiled in when STACK_BOUND_CHECK_EN is defined.
module mem_access_sequencer #(
  parameter logic [31:0] SP_INIT = 32'h0000_0FFF
`ifdef STACK_BOUND_CHECK_EN
  , parameter logic [31:0] SP_LIMIT = 32'h0000_0800
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [15:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] sp_out,
  output logic        stack_fault
);

  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_PUSH16 = 3'd3;
  localparam logic [2:0] OP_POP16  = 3'd4;
  localparam logic [2:0] OP_PUSH32 = 3'd5;
  localparam logic [2:0] OP_POP32  = 3'd6;

  typedef enum logic {IDLE, BEAT2} state_t;

  state_t      state_q, state_d;
  logic [31:0] sp_q, sp_d;
  logic [15:0] low_q, low_d;
  logic        isPush_q, isPush_d;
  logic        opFault_q, opFault_d;
  logic        opViol;

  logic [31:0] addrC;
  logic [15:0] wdataC;
  logic        readC, writeC, stallC, respValidC;
  logic [31:0] respDataC;

  logic push1Viol, push2Viol, pop1Viol, pop2Viol;

`ifdef STACK_BOUND_CHECK_EN
  logic fault_q;

  // Compared in 33 bits so the check sees the true (unwrapped) final SP.
  assign push1Viol = {1'b0, sp_q} < ({1'b0, SP_LIMIT} + 33'd1);
  assign push2Viol = {1'b0, sp_q} < ({1'b0, SP_LIMIT} + 33'd2);
  assign pop1Viol  = ({1'b0, sp_q} + 33'd1) > {1'b0, SP_INIT};
  assign pop2Viol  = ({1'b0, sp_q} + 33'd2) > {1'b0, SP_INIT};
  assign stack_fault = fault_q;
`else
  assign push1Viol = 1'b0;
  assign push2Viol = 1'b0;
  assign pop1Viol  = 1'b0;
  assign pop2Viol  = 1'b0;
  assign stack_fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    low_d      = low_q;
    isPush_d   = isPush_q;
    opFault_d  = opFault_q;
    opViol     = 1'b0;
    addrC      = '0;
    wdataC     = '0;
    readC      = 1'b0;
    writeC     = 1'b0;
    stallC     = 1'b0;
    respValidC = 1'b0;
    respDataC  = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_LOAD: begin
              addrC      = req_addr;
              readC      = 1'b1;
              respValidC = 1'b1;
              respDataC  = {16'h0000, mem_rdata};
            end
            OP_STORE: begin
              addrC      = req_addr;
              wdataC     = req_wdata[15:0];
              writeC     = 1'b1;
              respValidC = 1'b1;
            end
            OP_PUSH16: begin
              opViol     = push1Viol;
              addrC      = sp_q;
              wdataC     = req_wdata[15:0];
              writeC     = ~push1Viol;
              respValidC = 1'b1;
              if (!push1Viol) sp_d = sp_q - 32'd1;
            end
            OP_POP16: begin
              opViol     = pop1Viol;
              addrC      = sp_q + 32'd1;
              readC      = 1'b1;
              respValidC = 1'b1;
              respDataC  = {16'h0000, mem_rdata};
              if (!pop1Viol) sp_d = sp_q + 32'd1;
            end
            // Two-beat ops remember direction and fault so BEAT2 ignores req_*.
            OP_PUSH32: begin
              opViol    = push2Viol;
              addrC     = sp_q;
              wdataC    = req_wdata[31:16];
              writeC    = ~push2Viol;
              stallC    = 1'b1;
              low_d     = req_wdata[15:0];
              isPush_d  = 1'b1;
              opFault_d = push2Viol;
              state_d   = BEAT2;
            end
            OP_POP32: begin
              opViol    = pop2Viol;
              addrC     = sp_q + 32'd1;
              readC     = 1'b1;
              stallC    = 1'b1;
              low_d     = mem_rdata;
              isPush_d  = 1'b0;
              opFault_d = pop2Viol;
              state_d   = BEAT2;
            end
            default: ;
          endcase
        end
      end
      BEAT2: begin
        respValidC = 1'b1;
        state_d    = IDLE;
        if (isPush_q) begin
          addrC  = sp_q - 32'd1;
          wdataC = low_q;
          writeC = ~opFault_q;
          if (!opFault_q) sp_d = sp_q - 32'd2;
        end else begin
          addrC     = sp_q + 32'd2;
          readC     = 1'b1;
          respDataC = {mem_rdata, low_q};
          if (!opFault_q) sp_d = sp_q + 32'd2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sp_q      <= SP_INIT;
      low_q     <= '0;
      isPush_q  <= 1'b0;
      opFault_q <= 1'b0;
`ifdef STACK_BOUND_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      low_q     <= low_d;
      isPush_q  <= isPush_d;
      opFault_q <= opFault_d;
`ifdef STACK_BOUND_CHECK_EN
      fault_q   <= fault_q | opViol;
`endif
    end
  end

  // Holding reset silences the memory port even mid-op, so an abandoned BEAT2 never writes.
  assign mem_addr   = rst_n ? addrC      : '0;
  assign mem_wdata  = rst_n ? wdataC     : '0;
  assign mem_read   = rst_n & readC;
  assign mem_write  = rst_n & writeC;
  assign stall      = rst_n & stallC;
  assign resp_valid = rst_n & respValidC;
  assign resp_rdata = rst_n ? respDataC  : '0;
  assign sp_out     = sp_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized self-checking bench for mem_access_sequencer against a word-array stack model.
module tb_mem_access_sequencer;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH16 = 3'd3,
                         POP16 = 3'd4, PUSH32 = 3'd5, POP32 = 3'd6, OP7 = 3'd7;
`ifdef STACK_BOUND_CHECK_EN
  localparam bit boundCheck = 1'b1;
`else
  localparam bit boundCheck = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [15:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read, mem_write, stall, resp_valid;
  logic [31:0] resp_rdata, sp_out;
  logic        stack_fault;

  int assertCount = 0;
  int failCount   = 0;

  // Environment memory: written only by DUT writes, otherwise a fixed hashed pattern.
  logic [15:0] mem [0:8191];
  bit          written [0:8191];

  // Reference model state.
  logic [15:0] refMem [0:8191];
  logic [31:0] refSp;
  logic        refFault;

  mem_access_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .sp_out(sp_out), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] initVal(input logic [12:0] a);
    if (a == 13'h0010) return 16'hBEEF;
    return 16'({3'b000, a} * 16'h9E37) ^ 16'h5A5A;
  endfunction

  assign mem_rdata = written[mem_addr[12:0]] ? mem[mem_addr[12:0]] : initVal(mem_addr[12:0]);

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[12:0]]     <= mem_wdata;
      written[mem_addr[12:0]] <= 1'b1;
    end
  end

  function automatic logic modelViol(input logic [2:0] op, input logic [31:0] sp);
    longint s;
    s = longint'(sp);
    case (op)
      PUSH16:  return boundCheck && (s - 1 < 64'h800);
      PUSH32:  return boundCheck && (s - 2 < 64'h800);
      POP16:   return boundCheck && (s + 1 > 64'hFFF);
      POP32:   return boundCheck && (s + 2 > 64'hFFF);
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkState();
    @(posedge clk);
    #1;
    checkOutput("sp_out", sp_out, refSp);
    checkOutput("stack_fault", {31'b0, stack_fault}, {31'b0, refFault});
  endtask

  // Drives one request and checks every beat against the model.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic viol;
    logic [31:0] sp;
    sp = refSp;
    viol = modelViol(op, sp);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    #2;
    case (op)
      LOAD: begin
        checkOutput("load_read", {31'b0, mem_read}, 32'd1);
        checkOutput("load_addr", mem_addr, addr);
        checkOutput("load_rdata", resp_rdata, {16'h0, refMem[addr[12:0]]});
        checkOutput("load_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("load_stall", {31'b0, stall}, 32'd0);
      end
      STORE: begin
        checkOutput("store_write", {31'b0, mem_write}, 32'd1);
        checkOutput("store_addr", mem_addr, addr);
        checkOutput("store_wdata", {16'h0, mem_wdata}, {16'h0, wdata[15:0]});
        checkOutput("store_valid", {31'b0, resp_valid}, 32'd1);
        refMem[addr[12:0]] = wdata[15:0];
      end
      PUSH16: begin
        checkOutput("push16_addr", mem_addr, sp);
        checkOutput("push16_wdata", {16'h0, mem_wdata}, {16'h0, wdata[15:0]});
        checkOutput("push16_write", {31'b0, mem_write}, {31'b0, ~viol});
        checkOutput("push16_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("push16_stall", {31'b0, stall}, 32'd0);
        if (!viol) begin refMem[sp[12:0]] = wdata[15:0]; refSp = sp - 1; end
      end
      POP16: begin
        checkOutput("pop16_addr", mem_addr, sp + 1);
        checkOutput("pop16_rdata", resp_rdata, {16'h0, refMem[13'(sp + 1)]});
        checkOutput("pop16_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("pop16_stall", {31'b0, stall}, 32'd0);
        if (!viol) refSp = sp + 1;
      end
      PUSH32, POP32: begin
        checkOutput("b1_stall", {31'b0, stall}, 32'd1);
        checkOutput("b1_valid", {31'b0, resp_valid}, 32'd0);
        if (op == PUSH32) begin
          checkOutput("push32_b1_addr", mem_addr, sp);
          checkOutput("push32_b1_wdata", {16'h0, mem_wdata}, {16'h0, wdata[31:16]});
          checkOutput("push32_b1_write", {31'b0, mem_write}, {31'b0, ~viol});
          if (!viol) refMem[sp[12:0]] = wdata[31:16];
        end else begin
          checkOutput("pop32_b1_addr", mem_addr, sp + 1);
          checkOutput("pop32_b1_read", {31'b0, mem_read}, 32'd1);
        end
        @(posedge clk);
        #1;
        checkOutput("b1_sp_hold", sp_out, sp);
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(negedge clk);
        #2;
        checkOutput("b2_stall", {31'b0, stall}, 32'd0);
        checkOutput("b2_valid", {31'b0, resp_valid}, 32'd1);
        if (op == PUSH32) begin
          checkOutput("push32_b2_addr", mem_addr, sp - 1);
          checkOutput("push32_b2_wdata", {16'h0, mem_wdata}, {16'h0, wdata[15:0]});
          checkOutput("push32_b2_write", {31'b0, mem_write}, {31'b0, ~viol});
          if (!viol) begin refMem[13'(sp - 1)] = wdata[15:0]; refSp = sp - 2; end
        end else begin
          checkOutput("pop32_b2_addr", mem_addr, sp + 2);
          checkOutput("pop32_rdata", resp_rdata, {refMem[13'(sp + 2)], refMem[13'(sp + 1)]});
          if (!viol) refSp = sp + 2;
        end
      end
      default: begin
        checkOutput("nop_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("nop_write", {31'b0, mem_write}, 32'd0);
        checkOutput("nop_read", {31'b0, mem_read}, 32'd0);
        checkOutput("nop_addr", mem_addr, 32'd0);
      end
    endcase
    if (viol) refFault = 1'b1;
    checkState();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b1; req_op = PUSH16; req_addr = 32'h10; req_wdata = 32'h5555;
    @(negedge clk);
    #2;
    checkOutput("rst_write", {31'b0, mem_write}, 32'd0);
    checkOutput("rst_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    refSp = 32'h0FFF;
    refFault = 1'b0;
    #2;
    checkOutput("rst_sp", sp_out, 32'h0FFF);
    checkOutput("rst_fault", {31'b0, stack_fault}, 32'd0);
  endtask

  initial begin
    logic [2:0] op;
    rst_n = 1'b0; req_valid = 1'b0; req_op = NOP; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 8192; i++) refMem[i] = initVal(13'(i));
    refSp = 32'h0FFF;
    refFault = 1'b0;

    applyReset();
    applyStimulus(LOAD, 32'h10, 32'h0);
    applyStimulus(PUSH32, 32'h0, 32'h1234ABCD);
    applyStimulus(POP32, 32'h0, 32'h0);
    checkOutput("pop32_value_chain", {refMem[13'h0FFF], refMem[13'h0FFE]}, 32'h1234ABCD);

    // Reset in the middle of a PUSH32 abandons the second write.
    @(negedge clk);
    req_valid = 1'b1; req_op = PUSH32; req_wdata = 32'hCAFEF00D;
    #2;
    checkOutput("abort_b1_stall", {31'b0, stall}, 32'd1);
    refMem[13'h0FFF] = 16'hCAFE;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("abort_b2_write", {31'b0, mem_write}, 32'd0);
    checkOutput("abort_b2_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req_valid = 1'b0;
    refSp = 32'h0FFF;
    checkOutput("abort_sp", sp_out, 32'h0FFF);
    applyStimulus(LOAD, 32'h0FFE, 32'h0);
    applyStimulus(LOAD, 32'h0FFF, 32'h0);

    applyStimulus(PUSH16, 32'h0, 32'h0000_7E57);
    applyStimulus(POP16, 32'h0, 32'h0);
    applyStimulus(STORE, 32'h0123, 32'hFFFF_A5A5);
    checkOutput("b2b_net_sp", sp_out, 32'h0FFF);
    applyStimulus(NOP, 32'h44, 32'h1);
    applyStimulus(OP7, 32'h44, 32'h1);

    // POP16 at the top of the stack: faults with the bound check, wraps past SP_INIT without.
    applyStimulus(POP16, 32'h0, 32'h0);
    applyStimulus(LOAD, 32'h0123, 32'h0);
    applyReset();

    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      if ((op == PUSH16 || op == PUSH32) && refSp < 32'h0900) op = LOAD;
      if ((op == POP16 || op == POP32) && refSp + 2 > 32'h0FFF) op = STORE;
      applyStimulus(op, 32'($urandom_range(0, 8191)), $urandom);
    end

    @(negedge clk);
    req_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
